// File: rtl/stepper_controller.sv
// Memory-mapped full-step stepper sequencer.
// Runs a two-phase-on coil pattern and counts steps to completion.
module stepper_controller #(
    parameter logic [11:0]         BASE_ADDR      = 12'hF00,
    parameter int unsigned         PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address,
    input  logic [31:0] data,
    output logic [31:0] q_ctrl,
    output logic [3:0]  phase,
    output logic [1:0]  enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [11:0] OFF_STEPS  = 12'd0;
    localparam logic [11:0] OFF_PERIOD = 12'd1;
    localparam logic [11:0] OFF_CTRL   = 12'd2;
    localparam logic [11:0] OFF_STATUS = 12'd3;
    localparam logic [11:0] OFF_POS    = 12'd4;
    localparam logic [11:0] WIN_WORDS  = 12'd5;

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] TIMER_LAST = PERIOD_W'(1);

    state_t state_q, state_d;

    logic [1:0]          idx_q, idx_d;
    logic [15:0]         pos_q, pos_d;
    logic [15:0]         rem_q, rem_d;
    logic                dir_q, dir_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                hold_q, hold_d;
    logic                done_d;
    logic                drive_d;
    logic [31:0]         rd_data;

    logic [11:0] offset;
    logic        in_win;
    logic        wr_steps;
    logic        wr_period;
    logic        wr_ctrl;
    logic        wr_abort;
    logic        unused_data;

    // Coil pattern for each sequence index.
    function automatic logic [3:0] coil(input logic [1:0] i);
        logic [3:0] p;
        unique case (i)
            2'd0: p = 4'b1010;
            2'd1: p = 4'b0110;
            2'd2: p = 4'b0101;
            2'd3: p = 4'b1001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    // Window decode; the wrapping subtract keeps the compare one-sided.
    assign offset    = address - BASE_ADDR;
    assign in_win    = offset < WIN_WORDS;
    assign wr_steps  = wren && in_win && (offset == OFF_STEPS);
    assign wr_period = wren && in_win && (offset == OFF_PERIOD);
    assign wr_ctrl   = wren && in_win && (offset == OFF_CTRL);
    assign wr_abort  = wr_ctrl && data[0];

    assign unused_data = ^data;

    // Next-state and datapath update for the step sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_steps && (data[15:0] != 16'd0)) begin
                    state_d = RUN;
                    rem_d   = data[15:0];
                    dir_d   = data[31];
                    timer_d = period_q;
                end
            end
            RUN: begin
                if (wr_abort) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    if (dir_q) begin
                        idx_d = idx_q + 2'd1;
                        pos_d = pos_q + 16'd1;
                    end else begin
                        idx_d = idx_q - 2'd1;
                        pos_d = pos_q - 16'd1;
                    end
                    rem_d   = rem_q - 16'd1;
                    timer_d = period_q;
                    if (rem_q == 16'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TIMER_LAST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Software-visible configuration registers.
    always_comb begin
        period_d = period_q;
        hold_d   = hold_q;
        if (wr_period) begin
            if (data[PERIOD_W-1:0] < MIN_PERIOD) begin
                period_d = MIN_PERIOD;
            end else begin
                period_d = data[PERIOD_W-1:0];
            end
        end
        if (wr_ctrl) begin
            hold_d = data[1];
        end
    end

    assign drive_d = (state_d == RUN) || hold_d;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer datapath and configuration registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= 2'd0;
            pos_q    <= 16'd0;
            rem_q    <= 16'd0;
            dir_q    <= 1'b0;
            timer_q  <= '0;
            period_q <= DEFAULT_PERIOD;
            hold_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            hold_q   <= hold_d;
        end
    end

    // Registered coil and status outputs follow the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase  <= 4'b0000;
            enable <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            phase  <= drive_d ? coil(idx_d) : 4'b0000;
            enable <= drive_d ? 2'b11 : 2'b00;
            busy   <= (state_d == RUN);
            done   <= done_d;
        end
    end

    // Read mux over the register window.
    always_comb begin
        rd_data = 32'd0;
        if (in_win) begin
            unique case (offset)
                OFF_PERIOD: rd_data = 32'(period_q);
                OFF_CTRL:   rd_data = {30'd0, hold_q, 1'b0};
                OFF_STATUS: rd_data = {(state_q == RUN), dir_q, 14'd0, rem_q};
                OFF_POS:    rd_data = {{16{pos_q[15]}}, pos_q};
                default:    rd_data = 32'd0;
            endcase
        end
    end

    // One-cycle read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_ctrl <= 32'd0;
        end else begin
            q_ctrl <= rd_data;
        end
    end

endmodule

// File: tb/tb_stepper_controller.sv
// Bench for stepper_controller: directed scenarios plus random bus traffic.
// A cycle-count model predicts every registered output each clock.
module tb_stepper_controller;

    localparam logic [11:0] BASE = 12'hF00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic [11:0] address = 12'h000;
    logic [31:0] data = 32'd0;
    logic [31:0] q_ctrl;
    logic [3:0]  phase;
    logic [1:0]  enable;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail = 0;

    stepper_controller dut (
        .clock(clock),
        .reset(reset),
        .wren(wren),
        .address(address),
        .data(data),
        .q_ctrl(q_ctrl),
        .phase(phase),
        .enable(enable),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: steps happen at absolute cycle numbers.
    logic [3:0]  tbl [4] = '{4'b1010, 4'b0110, 4'b0101, 4'b1001};
    longint      cyc = 0;
    longint      m_next = 0;
    bit          m_run = 0;
    bit          m_dir = 0;
    bit          m_hold = 0;
    bit          m_done = 0;
    int          m_rem = 0;
    int          m_idx = 0;
    int          m_period = 100000;
    logic [15:0] m_pos = 16'd0;
    logic [31:0] m_q = 32'd0;

    initial begin
        logic [11:0] off;
        bit          inw;
        int          pv;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                m_run = 0; m_dir = 0; m_hold = 0; m_done = 0;
                m_rem = 0; m_idx = 0; m_period = 100000;
                m_pos = 16'd0; m_q = 32'd0;
            end else begin
                off = address - BASE;
                inw = (off < 12'd5);
                m_q = 32'd0;
                if (inw) begin
                    case (off)
                        12'd1: m_q = m_period;
                        12'd2: m_q = {30'd0, m_hold, 1'b0};
                        12'd3: m_q = {m_run, m_dir, 14'd0, 16'(m_rem)};
                        12'd4: m_q = {{16{m_pos[15]}}, m_pos};
                        default: m_q = 32'd0;
                    endcase
                end
                m_done = 0;
                if (m_run) begin
                    if (wren && inw && off == 12'd2 && data[0]) begin
                        m_run = 0;
                    end else if (cyc == m_next) begin
                        m_idx = m_dir ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
                        m_pos = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
                        m_rem--;
                        m_next = cyc + m_period;
                        if (m_rem == 0) begin
                            m_run = 0;
                            m_done = 1;
                        end
                    end
                end else if (wren && inw && off == 12'd0 &&
                             data[15:0] != 16'd0) begin
                    m_run = 1;
                    m_rem = data[15:0];
                    m_dir = data[31];
                    m_next = cyc + m_period;
                end
                if (wren && inw && off == 12'd1) begin
                    pv = int'(data[23:0]);
                    m_period = (pv < 2) ? 2 : pv;
                end
                if (wren && inw && off == 12'd2) m_hold = data[1];
            end
            #1;
            check("q_ctrl", q_ctrl, m_q);
            check("phase", 32'(phase),
                  (m_run || m_hold) ? 32'(tbl[m_idx]) : 32'd0);
            check("enable", 32'(enable),
                  (m_run || m_hold) ? 32'd3 : 32'd0);
            check("busy", 32'(busy), 32'(m_run));
            check("done", 32'(done), 32'(m_done));
        end
    end

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        address = BASE + 12'(off);
        data = d;
        wren = 1'b1;
        @(negedge clock);
        wren = 1'b0;
        address = 12'h000;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] v);
        address = BASE + 12'(off);
        wren = 1'b0;
        @(negedge clock);
        v = q_ctrl;
        address = 12'h000;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [31:0] v;
        int          op;

        wait_n(3);
        reset = 1'b0;

        // Reset state.
        rd(3'd1, v); check("reset_period", v, 32'd100000);
        rd(3'd3, v); check("reset_status", v, 32'd0);
        rd(3'd4, v); check("reset_pos", v, 32'd0);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_enable", 32'(enable), 32'd0);

        // Forward move of three steps, period 4.
        wr(3'd1, 32'd4);
        wr(3'd0, 32'h8000_0003);
        check("fwd_busy", 32'(busy), 32'd1);
        check("fwd_ph0", 32'(phase), 32'hA);
        wait_n(4); check("fwd_ph1", 32'(phase), 32'h6);
        wait_n(4); check("fwd_ph2", 32'(phase), 32'h5);
        check("fwd_nodone", 32'(done), 32'd0);
        wait_n(4);
        check("fwd_done", 32'(done), 32'd1);
        check("fwd_enable_off", 32'(enable), 32'd0);
        rd(3'd4, v); check("fwd_pos", v, 32'd3);

        // Reverse five steps with hold.
        wr(3'd2, 32'd2);
        check("hold_phase", 32'(phase), 32'h9);
        wr(3'd0, 32'h0000_0005);
        wait_n(20);
        check("rev_done", 32'(done), 32'd1);
        check("rev_phase", 32'(phase), 32'h5);
        check("rev_enable", 32'(enable), 32'd3);
        rd(3'd4, v); check("rev_pos", v, 32'hFFFF_FFFE);

        // Abort on the edge where the third step would land.
        wr(3'd1, 32'd10);
        wr(3'd0, 32'h8000_0064);
        wait_n(29);
        wr(3'd2, 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rd(3'd3, v); check("abort_status", v, 32'h4000_0062);

        // Writes during a move.
        wr(3'd1, 32'd6);
        wr(3'd0, 32'h8000_0004);
        wait_n(2);
        wr(3'd0, 32'h8000_0007);
        wr(3'd1, 32'd1);
        rd(3'd1, v); check("min_period", v, 32'd2);
        rd(3'd3, v); check("run_status", v, 32'hC000_0004);
        wait_n(10);
        wr(3'd0, 32'h8000_0000);
        check("zero_count_busy", 32'(busy), 32'd0);
        wait_n(2);

        // Reset in the middle of a move.
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h8000_000A);
        wait_n(6);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rd(3'd4, v); check("rst_pos", v, 32'd0);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, v); check("outside_read", v, 32'd0);
        rd(3'd1, v); check("outside_period", v, 32'd100000);

        // Random bus traffic checked by the model.
        wr(3'd1, 32'd3);
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 99);
            if (op < 25) begin
                wait_n($urandom_range(1, 8));
            end else if (op < 45) begin
                wr(3'd0, {1'($urandom_range(0, 1)), 15'd0,
                          16'($urandom_range(0, 6))});
            end else if (op < 55) begin
                wr(3'd1, 32'($urandom_range(0, 7)));
            end else if (op < 62) begin
                wr(3'd2, 32'($urandom_range(0, 3)));
            end else if (op < 92) begin
                rd(3'($urandom_range(0, 6)), v);
            end else if (op < 98) begin
                wr(3'($urandom_range(3, 7)), $urandom);
            end else begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                wr(3'd1, 32'($urandom_range(2, 5)));
            end
        end
        wait_n(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
